// File: rtl/datapath.sv
// Accumulator datapath: PC, IR, A and a 2**AW-word memory with registered read data,
// steered cycle by cycle by control words from the processor control unit.
module datapath #(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          IRload,
  input  logic          PCload,
  input  logic          JMPmux,
  input  logic          Meminst,
  input  logic          MemWr,
  input  logic [1:0]    Asel,
  input  logic          Aload,
  input  logic          Sub,
  input  logic [DW-1:0] InData,
  input  logic          LoadEn,
  input  logic [AW-1:0] LoadAddr,
  input  logic [DW-1:0] LoadData,
  output logic [2:0]    IR,
  output logic          Aeq0,
  output logic          Apos,
  output logic [DW-1:0] Aout,
  output logic [AW-1:0] PCout
);

  localparam logic [AW-1:0] PC_ONE = AW'(1);

  logic [DW-1:0] mem_q [2**AW];
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] md_q, md_d;
  logic [AW-1:0] raddr;
  logic [DW-1:0] alu;

  always_comb begin
    raddr = Meminst ? ir_q[AW-1:0] : pc_q;
    md_d  = mem_q[raddr];
    alu   = Sub ? (a_q - md_q) : (a_q + md_q);
    pc_d  = pc_q;
    if (PCload) pc_d = JMPmux ? ir_q[AW-1:0] : (pc_q + PC_ONE);
    ir_d  = IRload ? md_q : ir_q;
    a_d   = a_q;
    if (Aload) begin
      case (Asel)
        2'b00:   a_d = alu;
        2'b01:   a_d = InData;
        2'b10:   a_d = md_q;
        default: a_d = '0;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q <= '0;
      ir_q <= '0;
      a_q  <= '0;
      md_q <= '0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
      a_q  <= a_d;
      md_q <= md_d;
    end
  end

  // Contents survive reset; reset only blocks writes in its own cycle. The preload port wins.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      if (LoadEn)     mem_q[LoadAddr]     <= LoadData;
      else if (MemWr) mem_q[ir_q[AW-1:0]] <= a_q;
    end
  end

  assign IR    = ir_q[DW-1 -: 3];
  assign Aeq0  = (a_q == '0);
  assign Apos  = !a_q[DW-1] && (a_q != '0);
  assign Aout  = a_q;
  assign PCout = pc_q;

endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: directed control-word table, hand-built corner sequences,
// then random control words checked against an arithmetic model of the machine.
module tb_datapath;

  logic       Clock = 1'b0;
  logic       Reset, IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, LoadEn;
  logic [1:0] Asel;
  logic [7:0] InData, LoadData, Aout;
  logic [4:0] LoadAddr, PCout;
  logic [2:0] IR;
  logic       Aeq0, Apos;

  datapath #(.DW(8), .AW(5)) dut (
    .Clock(Clock), .Reset(Reset), .IRload(IRload), .PCload(PCload), .JMPmux(JMPmux),
    .Meminst(Meminst), .MemWr(MemWr), .Asel(Asel), .Aload(Aload), .Sub(Sub),
    .InData(InData), .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData),
    .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .Aout(Aout), .PCout(PCout)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic       rst, irl, pcl, jmp, mi, mw;
    logic [1:0] asel;
    logic       al, sb;
    logic [7:0] ind;
    logic       le;
    logic [4:0] la;
    logic [7:0] ld;
  } ctl_t;

  typedef struct {
    ctl_t c;
    int   eir, ea, epc;
  } vec_t;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  // Reference machine state
  int m_mem [32];
  int m_pc, m_ir, m_a, m_md;

  function automatic ctl_t ctl(int rst, int irl, int pcl, int jmp, int mi, int mw, int asel,
                               int al, int sb, int ind, int le, int la, int ld);
    ctl_t c;
    c.rst = rst[0]; c.irl = irl[0]; c.pcl = pcl[0]; c.jmp = jmp[0];
    c.mi  = mi[0];  c.mw  = mw[0];  c.asel = asel[1:0];
    c.al  = al[0];  c.sb  = sb[0];  c.ind = ind[7:0];
    c.le  = le[0];  c.la  = la[4:0]; c.ld = ld[7:0];
    return c;
  endfunction

  function automatic vec_t row(ctl_t c, int eir, int ea, int epc);
    vec_t v;
    v.c = c; v.eir = eir; v.ea = ea; v.epc = epc;
    return v;
  endfunction

  task automatic model_step(input ctl_t c);
    int raddr, nmd, alu, npc;
    if (c.rst) begin
      m_pc = 0; m_ir = 0; m_a = 0; m_md = 0;
      return;
    end
    raddr = c.mi ? (m_ir % 32) : m_pc;
    nmd   = m_mem[raddr];
    if (c.le)      m_mem[int'(c.la)] = int'(c.ld);
    else if (c.mw) m_mem[m_ir % 32]  = m_a;
    npc = m_pc;
    if (c.pcl) npc = c.jmp ? (m_ir % 32) : ((m_pc + 1) % 32);
    alu = c.sb ? ((m_a - m_md + 256) % 256) : ((m_a + m_md) % 256);
    if (c.al) begin
      case (int'(c.asel))
        0:       m_a = alu;
        1:       m_a = int'(c.ind);
        2:       m_a = m_md;
        default: m_a = 0;
      endcase
    end
    if (c.irl) m_ir = m_md;
    m_pc = npc;
    m_md = nmd;
  endtask

  task automatic cycle(input ctl_t c);
    Reset = c.rst; IRload = c.irl; PCload = c.pcl; JMPmux = c.jmp; Meminst = c.mi;
    MemWr = c.mw; Asel = c.asel; Aload = c.al; Sub = c.sb; InData = c.ind;
    LoadEn = c.le; LoadAddr = c.la; LoadData = c.ld;
    @(posedge Clock);
    model_step(c);
    @(negedge Clock);
  endtask

  task automatic check(input string name, input int act, input int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Flags are derived from the expected accumulator by their defining rule.
  task automatic check_out(input string tag, input int eir, input int ea, input int epc);
    check({tag, ".ir"},   int'(IR),    eir);
    check({tag, ".a"},    int'(Aout),  ea);
    check({tag, ".pc"},   int'(PCout), epc);
    check({tag, ".aeq0"}, int'(Aeq0),  int'(ea == 0));
    check({tag, ".apos"}, int'(Apos),  int'(ea != 0 && ea < 128));
  endtask

  ctl_t I;
  vec_t tbl [$];
  int   init_mem [32];

  initial begin
    Reset = 1'b1; IRload = 0; PCload = 0; JMPmux = 0; Meminst = 0; MemWr = 0;
    Asel = 2'b00; Aload = 0; Sub = 0; InData = 0; LoadEn = 0; LoadAddr = 0; LoadData = 0;
    I = ctl(0,0,0,0,0,0,0,0,0,0,0,0,0);
    @(negedge Clock);
    cycle(ctl(1,0,0,0,0,0,0,0,0,0,0,0,0));
    check_out("init_rst", 0, 0, 0);

    // Preload: program at 0..5, operands at 16..31, random filler elsewhere
    for (int i = 0; i < 32; i++) init_mem[i] = $urandom_range(0, 255);
    init_mem[0]  = 'h10; init_mem[1]  = 'h31; init_mem[2]  = 'h32; init_mem[3]  = 'h77;
    init_mem[4]  = 'h34; init_mem[5]  = 'hB5; init_mem[16] = 'h05; init_mem[17] = 'h0A;
    init_mem[18] = 'h10; init_mem[21] = 'hFF; init_mem[23] = 'h80; init_mem[31] = 'h40;
    for (int i = 0; i < 32; i++) cycle(ctl(0,0,0,0,0,0,0,0,0,0,1,i,init_mem[i]));

    //                  rst irl pcl jmp mi mw asel al sb  ind le la  ld    ir   a     pc
    tbl.push_back(row(ctl(1, 1, 1, 0, 0, 0, 1,  1, 0, 'h55, 1, 3, 'h00), 0, 'h00, 0));  // reset wins
    tbl.push_back(row(ctl(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,    0, 0, 0),    0, 'h00, 0));  // start
    tbl.push_back(row(ctl(0, 1, 1, 0, 0, 0, 0,  0, 0, 0,    0, 0, 0),    0, 'h00, 1));  // fetch 0x10
    tbl.push_back(row(ctl(0, 0, 0, 0, 1, 0, 0,  0, 0, 0,    0, 0, 0),    0, 'h00, 1));  // decode
    tbl.push_back(row(ctl(0, 0, 0, 0, 1, 0, 2,  1, 0, 0,    0, 0, 0),    0, 'h05, 1));  // load M[16]
    tbl.push_back(row(ctl(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,    0, 0, 0),    0, 'h05, 1));
    tbl.push_back(row(ctl(0, 1, 1, 0, 0, 0, 0,  0, 0, 0,    0, 0, 0),    1, 'h05, 2));  // fetch 0x31
    tbl.push_back(row(ctl(0, 0, 0, 0, 1, 0, 0,  0, 0, 0,    0, 0, 0),    1, 'h05, 2));
    tbl.push_back(row(ctl(0, 0, 0, 0, 1, 0, 0,  1, 0, 0,    0, 0, 0),    1, 'h0F, 2));  // add 0x0A
    tbl.push_back(row(ctl(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,    0, 0, 0),    1, 'h0F, 2));
    tbl.push_back(row(ctl(0, 1, 1, 0, 0, 0, 0,  0, 0, 0,    0, 0, 0),    1, 'h0F, 3));  // fetch 0x32
    tbl.push_back(row(ctl(0, 0, 0, 0, 1, 0, 0,  0, 0, 0,    0, 0, 0),    1, 'h0F, 3));
    tbl.push_back(row(ctl(0, 0, 0, 0, 1, 0, 0,  1, 1, 0,    0, 0, 0),    1, 'hFF, 3));  // sub 0x10
    tbl.push_back(row(ctl(0, 0, 0, 0, 0, 0, 1,  1, 0, 'h80, 0, 0, 0),    1, 'h80, 3));  // InData
    tbl.push_back(row(ctl(0, 0, 0, 0, 0, 0, 1,  0, 0, 'h7F, 0, 0, 0),    1, 'h80, 3));  // hold
    tbl.push_back(row(ctl(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,    0, 0, 0),    1, 'h80, 3));
    tbl.push_back(row(ctl(0, 1, 1, 0, 0, 0, 0,  0, 0, 0,    0, 0, 0),    3, 'h80, 4));  // fetch 0x77
    tbl.push_back(row(ctl(0, 0, 0, 0, 1, 0, 0,  0, 0, 0,    0, 0, 0),    3, 'h80, 4));
    tbl.push_back(row(ctl(0, 0, 0, 0, 1, 0, 0,  1, 0, 0,    0, 0, 0),    3, 'h00, 4));  // 80+80
    tbl.push_back(row(ctl(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,    0, 0, 0),    3, 'h00, 4));
    tbl.push_back(row(ctl(0, 1, 1, 0, 0, 0, 0,  0, 0, 0,    0, 0, 0),    1, 'h00, 5));  // fetch 0x34
    tbl.push_back(row(ctl(0, 0, 0, 0, 0, 0, 1,  1, 0, 'h2A, 0, 0, 0),    1, 'h2A, 5));
    tbl.push_back(row(ctl(0, 0, 0, 0, 1, 1, 0,  0, 0, 0,    0, 0, 0),    1, 'h2A, 5));  // store M[20]
    tbl.push_back(row(ctl(0, 0, 0, 0, 0, 0, 3,  1, 0, 0,    0, 0, 0),    1, 'h00, 5));  // clear A
    tbl.push_back(row(ctl(0, 0, 0, 0, 1, 0, 0,  0, 0, 0,    0, 0, 0),    1, 'h00, 5));
    tbl.push_back(row(ctl(0, 0, 0, 0, 1, 0, 2,  1, 0, 0,    0, 0, 0),    1, 'h2A, 5));  // reload M[20]
    tbl.push_back(row(ctl(0, 0, 0, 0, 1, 1, 0,  0, 0, 0,    1, 20, 'h11), 1, 'h2A, 5)); // LoadEn wins
    tbl.push_back(row(ctl(0, 0, 0, 0, 1, 0, 0,  0, 0, 0,    0, 0, 0),    1, 'h2A, 5));
    tbl.push_back(row(ctl(0, 0, 0, 0, 1, 0, 2,  1, 0, 0,    0, 0, 0),    1, 'h11, 5));
    tbl.push_back(row(ctl(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,    0, 0, 0),    1, 'h11, 5));
    tbl.push_back(row(ctl(0, 1, 1, 0, 0, 0, 0,  0, 0, 0,    0, 0, 0),    5, 'h11, 6));  // fetch 0xB5
    tbl.push_back(row(ctl(0, 0, 1, 1, 0, 0, 0,  0, 0, 0,    0, 0, 0),    5, 'h11, 21)); // jump
    tbl.push_back(row(ctl(0, 0, 0, 1, 0, 0, 0,  0, 0, 0,    0, 0, 0),    5, 'h11, 21)); // no PCload
    tbl.push_back(row(ctl(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,    0, 0, 0),    5, 'h11, 21));
    tbl.push_back(row(ctl(0, 1, 1, 0, 0, 0, 0,  0, 0, 0,    0, 0, 0),    7, 'h11, 22)); // fetch 0xFF
    tbl.push_back(row(ctl(0, 0, 1, 1, 0, 0, 0,  0, 0, 0,    0, 0, 0),    7, 'h11, 31)); // jump 31
    tbl.push_back(row(ctl(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,    0, 0, 0),    7, 'h11, 31));
    tbl.push_back(row(ctl(0, 1, 1, 0, 0, 0, 0,  0, 0, 0,    0, 0, 0),    2, 'h11, 0));  // PC wraps

    foreach (tbl[i]) begin
      cycle(tbl[i].c);
      check_out($sformatf("row%0d", i), tbl[i].eir, tbl[i].ea, tbl[i].epc);
    end

    // Read-before-write: IR addresses M[0] (holds 0x10) while A=0x11 is stored there
    cycle(ctl(0,0,0,0,1,1,0,0,0,0,0,0,0));
    cycle(ctl(0,0,0,0,0,0,2,1,0,0,0,0,0));
    check("rbw_old", int'(Aout), 'h10);
    cycle(ctl(0,0,0,0,0,0,2,1,0,0,0,0,0));
    check("rbw_new", int'(Aout), 'h11);

    // Reset in the middle of a store: the write to M[0] must be dropped
    cycle(ctl(0,0,0,0,0,0,1,1,0,'h99,0,0,0));
    check("pre_rst_a", int'(Aout), 'h99);
    cycle(ctl(1,1,1,1,1,1,1,1,0,'h99,0,0,0));
    check_out("mid_rst", 0, 0, 0);
    cycle(ctl(0,0,0,0,1,0,0,0,0,0,0,0,0));
    cycle(ctl(0,0,0,0,1,0,2,1,0,0,0,0,0));
    check("rst_drop_wr", int'(Aout), 'h11);

    // Random control words against the reference machine
    for (int n = 0; n < 400; n++) begin
      int rst, le;
      rst = int'($urandom_range(0, 40) == 0);
      le  = int'($urandom_range(0, 3) == 0);
      cycle(ctl(rst, $urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1),
                $urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,3),
                $urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,255),
                le, $urandom_range(0,31), $urandom_range(0,255)));
      check_out($sformatf("rnd%0d", n), m_ir / 32, m_a, m_pc);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
